// File: rtl/serial_alu_unit_pkg.sv
// Shared constants for the bit-serial ALU: opcode width, opcode encodings,
// the highest legal opcode and a legality helper.
package serial_alu_unit_pkg;

    localparam int MUX_WIDTH = 3;

    typedef logic [MUX_WIDTH-1:0] op_t;

    localparam op_t OP_AND       = 3'b000;
    localparam op_t OP_OR        = 3'b001;
    localparam op_t OP_XOR       = 3'b010;
    localparam op_t OP_ADD       = 3'b011;
    localparam op_t OP_SUB       = 3'b100;
    localparam op_t OP_LEGAL_MAX = 3'b100;

    function automatic logic is_legal(input op_t f);
        return f <= OP_LEGAL_MAX;
    endfunction

endpackage

// File: rtl/serial_alu_unit_if.sv
// Request/result bundle of the bit-serial ALU.
//  master: drives start_i, f_i, a_i, b_i; observes busy/done/result/flags
//  slave : the ALU itself
interface serial_alu_unit_if #(parameter int WIDTH = 8);
    import serial_alu_unit_pkg::*;

    logic             start_i;
    op_t              f_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             zero_o;
    logic             illegal_o;

    modport master (
        output start_i, f_i, a_i, b_i,
        input  busy_o, done_o, result_o, carry_o, zero_o, illegal_o
    );

    modport slave (
        input  start_i, f_i, a_i, b_i,
        output busy_o, done_o, result_o, carry_o, zero_o, illegal_o
    );

endinterface

// File: rtl/serial_alu_unit_mux.sv
// 1-bit result selector: picks one of the five per-bit slices by opcode.
//  and_r_i..subtractor_r_i : candidate result bits
//  f_i                     : opcode
//  result_o                : selected bit (0 for illegal opcodes)
module serial_alu_unit_mux
    import serial_alu_unit_pkg::*;
(
    input  logic and_r_i,
    input  logic or_r_i,
    input  logic xor_r_i,
    input  logic adder_r_i,
    input  logic subtractor_r_i,
    input  op_t  f_i,
    output logic result_o
);

    always_comb begin
        result_o = 1'b0;
        case (f_i)
            OP_AND:  result_o = and_r_i;
            OP_OR:   result_o = or_r_i;
            OP_XOR:  result_o = xor_r_i;
            OP_ADD:  result_o = adder_r_i;
            OP_SUB:  result_o = subtractor_r_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_unit.sv
// Bit-serial ALU: latches A, B and opcode on start, processes one bit per
// clock LSB first, then publishes result, carry and zero with a done pulse.
//  clk_i, rst_ni : clock (rising edge), async active-low reset
//  bus (slave)   : start/f/a/b request, busy/done/result/carry/zero/illegal
module serial_alu_unit
    import serial_alu_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    serial_alu_unit_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    op_t              f_q, f_d;
    // Only the upper WIDTH-1 shift positions are stored: the bit produced on
    // the last step goes straight into the result via shift_full.
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;

    logic             is_sub, is_arith;
    logic             a_bit, b_bit, b_eff, sum_bit, cout_bit, sel_bit;
    logic [WIDTH-1:0] shift_full;

    assign is_sub   = (f_q == OP_SUB);
    assign is_arith = (f_q == OP_ADD) || is_sub;
    assign a_bit    = a_q[cnt_q];
    assign b_bit    = b_q[cnt_q];
    // SUB is A + ~B + 1: invert B here, the +1 is the preset carry.
    assign b_eff    = b_bit ^ is_sub;
    assign sum_bit  = a_bit ^ b_eff ^ c_q;
    assign cout_bit = (a_bit & b_eff) | (a_bit & c_q) | (b_eff & c_q);

    serial_alu_unit_mux u_mux (
        .and_r_i        (a_bit & b_bit),
        .or_r_i         (a_bit | b_bit),
        .xor_r_i        (a_bit ^ b_bit),
        .adder_r_i      (sum_bit),
        .subtractor_r_i (sum_bit),
        .f_i            (f_q),
        .result_o       (sel_bit)
    );

    assign shift_full = {sel_bit, sh_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        sh_d    = sh_q;
        c_d     = c_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (is_legal(bus.f_i)) begin
                        a_d     = bus.a_i;
                        b_d     = bus.b_i;
                        f_d     = bus.f_i;
                        cnt_d   = '0;
                        c_d     = (bus.f_i == OP_SUB);
                        state_d = S_RUN;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                sh_d  = shift_full[WIDTH-1:1];
                cnt_d = cnt_q + CW'(1);
                if (is_arith) c_d = cout_bit;
                if (cnt_q == LAST) begin
                    res_d   = shift_full;
                    carry_d = is_arith & cout_bit;
                    zero_d  = (shift_full == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            sh_q    <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            sh_q    <= sh_d;
            c_q     <= c_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.done_o    = done_q;
    assign bus.result_o  = res_q;
    assign bus.carry_o   = carry_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = ill_q;

endmodule

// File: tb/tb_serial_alu_unit.sv
// Self-checking bench for serial_alu_unit (WIDTH=8): directed cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_serial_alu_unit;
    import serial_alu_unit_pkg::*;

    localparam int W = 8;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [W-1:0] exp_res = '0;
    logic         exp_carry = 1'b0;
    logic         exp_zero = 1'b0;

    serial_alu_unit_if #(.WIDTH(W)) bus ();

    serial_alu_unit #(.WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole-word arithmetic from the opcode definitions.
    task automatic model(input op_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c);
        logic [W:0] s;
        c = 1'b0;
        case (f)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            default: begin r = a - b; c = (a >= b); end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one legal operation and check latency, hold, result and flags.
    // inject: pulse another start mid-run, which must be ignored.
    task automatic run_op(input string tag, input op_t f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit inject);
        int cyc;
        bit hold_ok;
        logic [W-1:0] r;
        logic c;
        model(f, a, b, r, c);
        bus.start_i = 1'b1; bus.f_i = f; bus.a_i = a; bus.b_i = b;
        tick();
        bus.start_i = 1'b0;
        bus.a_i = $urandom; bus.b_i = $urandom;
        cyc = 1;
        hold_ok = 1'b1;
        while (!bus.done_o && cyc < 40) begin
            if (bus.busy_o !== 1'b1 || bus.result_o !== exp_res) hold_ok = 1'b0;
            if (inject && cyc == 3) begin
                bus.start_i = 1'b1; bus.f_i = OP_ADD; bus.a_i = 8'hFF; bus.b_i = 8'hFF;
            end else begin
                bus.start_i = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start_i = 1'b0;
        chk({tag, " done"}, {31'd0, bus.done_o}, 32'd1);
        chk({tag, " latency"}, cyc, W + 1);
        chk({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        exp_res = r; exp_carry = c; exp_zero = (r == '0);
        chk({tag, " result"}, {24'd0, bus.result_o}, {24'd0, exp_res});
        chk({tag, " carry"}, {31'd0, bus.carry_o}, {31'd0, exp_carry});
        chk({tag, " zero"}, {31'd0, bus.zero_o}, {31'd0, exp_zero});
        tick();
        chk({tag, " done pulse"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.f_i = '0; bus.a_i = '0; bus.b_i = '0;
        #12;
        chk("reset result", {24'd0, bus.result_o}, 32'd0);
        chk("reset flags", {26'd0, bus.busy_o, bus.done_o, bus.carry_o, bus.zero_o,
                            bus.illegal_o, 1'b0}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        run_op("add1", OP_ADD, 8'h3C, 8'h0F, 1'b0);
        run_op("add2", OP_ADD, 8'hFF, 8'h01, 1'b0);
        run_op("sub1", OP_SUB, 8'h05, 8'h07, 1'b0);
        run_op("sub2", OP_SUB, 8'h07, 8'h07, 1'b0);
        run_op("and", OP_AND, 8'hA5, 8'h3C, 1'b0);
        run_op("or",  OP_OR,  8'hA5, 8'h3C, 1'b0);
        run_op("xor", OP_XOR, 8'hA5, 8'h3C, 1'b0);

        // Illegal opcode: one registered pulse, no acceptance.
        bus.start_i = 1'b1; bus.f_i = 3'b101; bus.a_i = 8'h11; bus.b_i = 8'h22;
        tick();
        bus.start_i = 1'b0;
        chk("illegal pulse", {31'd0, bus.illegal_o}, 32'd1);
        chk("illegal busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        chk("illegal clear", {31'd0, bus.illegal_o}, 32'd0);
        chk("illegal busy2", {31'd0, bus.busy_o}, 32'd0);
        chk("illegal result", {24'd0, bus.result_o}, {24'd0, exp_res});

        // Start during RUN must be dropped, not queued.
        run_op("inject", OP_ADD, 8'h12, 8'h34, 1'b1);
        tick();
        chk("no queue", {31'd0, bus.busy_o}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            op_t f;
            f = op_t'($urandom_range(0, 4));
            run_op("rand", f, W'($urandom), W'($urandom), 1'b0);
        end

        // Reset mid-run at cnt=4.
        bus.start_i = 1'b1; bus.f_i = OP_XOR; bus.a_i = 8'hA5; bus.b_i = 8'h3C;
        tick();
        bus.start_i = 1'b0;
        repeat (4) tick();
        rst_ni = 1'b0;
        #1;
        chk("abort result", {24'd0, bus.result_o}, 32'd0);
        chk("abort flags", {26'd0, bus.busy_o, bus.done_o, bus.carry_o, bus.zero_o,
                            bus.illegal_o, 1'b0}, 32'd0);
        exp_res = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        run_op("post rst", OP_ADD, 8'h01, 8'h01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
